// File: rtl/id_hazard_scoreboard.sv
// Decode-stage register scoreboard: per-register pending countdowns, stall request and prioritised operand forwarding.
// Optional stall statistics counter enabled by defining SCOREBOARD_STATS_EN.
module id_hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int NFWD    = 3,
    parameter int MAX_LAT = 7,
    parameter int LW      = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       pipe_hold,
    input  logic                       issue_valid,
    input  logic [AW-1:0]              issue_waddr,
    input  logic [LW-1:0]              issue_lat,
    input  logic [AW-1:0]              rs_addr,
    input  logic [AW-1:0]              rt_addr,
    input  logic                       rs_use,
    input  logic                       rt_use,
    input  logic [DW-1:0]              rf_rdata1,
    input  logic [DW-1:0]              rf_rdata2,
    input  logic [NFWD*(1+AW+DW)-1:0]  fwd_bus,
    output logic [DW-1:0]              rs_data,
    output logic [DW-1:0]              rt_data,
    output logic                       stallreq,
    output logic                       busy,
    output logic [31:0]                stall_cycles
);

    localparam int EW = 1 + AW + DW;

    logic [NREG-1:0] pending;
    logic [LW-1:0]   cnt [NREG];
    logic            issue_accept;
    logic [LW-1:0]   lat_eff;
    logic            rs_hit;
    logic            rt_hit;

    assign rs_hit   = rs_use & (rs_addr != '0) & pending[rs_addr];
    assign rt_hit   = rt_use & (rt_addr != '0) & pending[rt_addr];
    assign stallreq = rs_hit | rt_hit;
    assign busy     = |pending;

    assign issue_accept = issue_valid & ~stallreq & ~pipe_hold & ~flush & (issue_waddr != '0);
    // Defensive clamp; the latency field is sized so this never engages in practice.
    assign lat_eff = (issue_lat > LW'(MAX_LAT)) ? LW'(MAX_LAT) : issue_lat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else if (flush) begin
            pending <= '0;
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else if (!pipe_hold) begin
            pending[0] <= 1'b0;
            cnt[0]     <= '0;
            for (int r = 1; r < NREG; r++) begin
                // A younger issue to the same register overrides its running countdown.
                if (issue_accept && (issue_waddr == AW'(r))) begin
                    cnt[r]     <= lat_eff;
                    pending[r] <= (lat_eff != '0);
                end else if (cnt[r] != '0) begin
                    cnt[r]     <= cnt[r] - LW'(1);
                    pending[r] <= (cnt[r] != LW'(1));
                end
            end
        end
    end

    function automatic logic [DW-1:0] resolve(input logic [AW-1:0] addr,
                                              input logic [DW-1:0] rf,
                                              input logic [NFWD*EW-1:0] bus);
        logic [DW-1:0] val;
        logic [EW-1:0] entry;
        val = rf;
        // Walk oldest to youngest so the lowest-index match is the one left standing.
        for (int i = NFWD - 1; i >= 0; i--) begin
            entry = bus[i*EW +: EW];
            if (entry[EW-1] && (entry[DW +: AW] == addr)) val = entry[DW-1:0];
        end
        if (addr == '0) val = '0;
        return val;
    endfunction

    assign rs_data = resolve(rs_addr, rf_rdata1, fwd_bus);
    assign rt_data = resolve(rt_addr, rf_rdata2, fwd_bus);

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= '0;
        end else if (stallreq && !pipe_hold && (stat_q != 32'hFFFF_FFFF)) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stall_cycles = stat_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Scoreboard bench for id_hazard_scoreboard: directed scenarios plus random traffic against a countdown-array reference model.
module tb_id_hazard_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NFWD = 3;
    localparam int LW   = 3;
    localparam int EW   = 1 + AW + DW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush, pipe_hold, issue_valid;
    logic [AW-1:0]        issue_waddr, rs_addr, rt_addr;
    logic [LW-1:0]        issue_lat;
    logic                 rs_use, rt_use;
    logic [DW-1:0]        rf_rdata1, rf_rdata2;
    logic [NFWD*EW-1:0]   fwd_bus;
    logic [DW-1:0]        rs_data, rt_data;
    logic                 stallreq, busy;
    logic [31:0]          stall_cycles;

    always #5 clk = ~clk;

    id_hazard_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush), .pipe_hold(pipe_hold),
        .issue_valid(issue_valid), .issue_waddr(issue_waddr), .issue_lat(issue_lat),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_use(rs_use), .rt_use(rt_use),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_bus(fwd_bus),
        .rs_data(rs_data), .rt_data(rt_data), .stallreq(stallreq), .busy(busy),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic                      issue_valid;
        logic [AW-1:0]             issue_waddr;
        logic [LW-1:0]             issue_lat;
        logic [AW-1:0]             rs_addr, rt_addr;
        logic                      rs_use, rt_use;
        logic [DW-1:0]             rf1, rf2;
        logic [NFWD-1:0]           we;
        logic [NFWD-1:0][AW-1:0]   wa;
        logic [NFWD-1:0][DW-1:0]   wd;
        logic                      flush, hold;
    } stim_t;

    typedef struct {
        int          cyc;
        logic        stall, busy;
        logic [31:0] rs_data, rt_data, stat;
    } exp_t;

    exp_t        exp_q[$];
    int          rem[NREG];
    logic [31:0] stat_model;
    int          cyc_no;
    int          n_compared;
    int          n_mismatch;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic logic [31:0] model_resolve(input logic [AW-1:0] a, input logic [DW-1:0] rf, input stim_t s);
        if (a == 0) return 32'd0;
        for (int i = 0; i < NFWD; i++)
            if (s.we[i] && s.wa[i] == a) return s.wd[i];
        return rf;
    endfunction

    function automatic exp_t model_outputs(input stim_t s);
        exp_t e;
        e.cyc     = cyc_no;
        e.stall   = (s.rs_use && s.rs_addr != 0 && rem[s.rs_addr] > 0) ||
                    (s.rt_use && s.rt_addr != 0 && rem[s.rt_addr] > 0);
        e.busy    = 1'b0;
        for (int r = 0; r < NREG; r++) if (rem[r] > 0) e.busy = 1'b1;
        e.rs_data = model_resolve(s.rs_addr, s.rf1, s);
        e.rt_data = model_resolve(s.rt_addr, s.rf2, s);
        e.stat    = stat_model;
        return e;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) rem[r] = 0;
        stat_model = 32'd0;
    endtask

    // Reference state advance: remaining-cycle counts per register, updated once per clock edge.
    task automatic model_update(input stim_t s, input logic stall);
`ifdef SCOREBOARD_STATS_EN
        if (stall && !s.hold && stat_model != 32'hFFFF_FFFF) stat_model = stat_model + 1;
`endif
        if (s.flush) begin
            for (int r = 0; r < NREG; r++) rem[r] = 0;
        end else if (!s.hold) begin
            for (int r = 0; r < NREG; r++) if (rem[r] > 0) rem[r] = rem[r] - 1;
            if (s.issue_valid && !stall && s.issue_waddr != 0) rem[s.issue_waddr] = int'(s.issue_lat);
        end
    endtask

    task automatic drive(input stim_t s);
        issue_valid = s.issue_valid;
        issue_waddr = s.issue_waddr;
        issue_lat   = s.issue_lat;
        rs_addr     = s.rs_addr;
        rt_addr     = s.rt_addr;
        rs_use      = s.rs_use;
        rt_use      = s.rt_use;
        rf_rdata1   = s.rf1;
        rf_rdata2   = s.rf2;
        flush       = s.flush;
        pipe_hold   = s.hold;
        for (int i = 0; i < NFWD; i++) fwd_bus[i*EW +: EW] = {s.we[i], s.wa[i], s.wd[i]};
    endtask

    task automatic apply_stimulus(input stim_t s);
        exp_t e;
        drive(s);
        e = model_outputs(s);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        model_update(s, e.stall);
        cyc_no++;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req, input int cyc);
        n_compared++;
        if (act !== req) begin
            n_mismatch++;
            $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Monitor: compares the DUT against the oldest queued expectation half a cycle after each drive.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("stallreq",     32'(stallreq), 32'(e.stall), e.cyc);
            check_output("busy",         32'(busy),     32'(e.busy),  e.cyc);
            check_output("rs_data",      rs_data,       e.rs_data,    e.cyc);
            check_output("rt_data",      rt_data,       e.rt_data,    e.cyc);
            check_output("stall_cycles", stall_cycles,  e.stat,       e.cyc);
        end
    end

    task automatic check_reset_state(input string tag);
        check_output({tag, "_stallreq"}, 32'(stallreq), 32'd0, cyc_no);
        check_output({tag, "_busy"},     32'(busy),     32'd0, cyc_no);
        check_output({tag, "_stats"},    stall_cycles,  32'd0, cyc_no);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        stim_t s;
        n_compared = 0;
        n_mismatch = 0;
        cyc_no     = 0;
        model_reset();
        drive(idle());
        rst = 1'b0;
        #1;
        check_reset_state("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Idle read of r5 from the regfile
        s = idle(); s.rs_addr = 5; s.rs_use = 1; s.rf1 = 32'h1234;
        apply_stimulus(s);

        // Load to r8 with lat 1, dependent read, then forwarded from entry 1
        s = idle(); s.issue_valid = 1; s.issue_waddr = 8; s.issue_lat = 1;
        apply_stimulus(s);
        s = idle(); s.rt_addr = 8; s.rt_use = 1; s.rf2 = 32'h5555;
        apply_stimulus(s);
        s.we[1] = 1; s.wa[1] = 8; s.wd[1] = 32'hCAFE;
        apply_stimulus(s);

        // lat 4 with a two-cycle hold on the reader
        s = idle(); s.issue_valid = 1; s.issue_waddr = 3; s.issue_lat = 4;
        apply_stimulus(s);
        for (int k = 0; k < 8; k++) begin
            s = idle(); s.rs_addr = 3; s.rs_use = 1; s.rf1 = 32'h33;
            s.hold = (k == 1 || k == 2);
            apply_stimulus(s);
        end

        // Write-after-write: lat 0 issue clears the pending lat 4 entry
        s = idle(); s.issue_valid = 1; s.issue_waddr = 3; s.issue_lat = 4;
        apply_stimulus(s);
        s = idle(); s.issue_valid = 1; s.issue_waddr = 3; s.issue_lat = 0;
        apply_stimulus(s);
        s = idle(); s.rs_addr = 3; s.rs_use = 1; s.rf1 = 32'h77;
        s.we = 3'b101; s.wa[0] = 3; s.wa[2] = 3; s.wd[0] = 32'hA; s.wd[2] = 32'hB;
        apply_stimulus(s);

        // Flush after one cycle of a lat 5 countdown
        s = idle(); s.issue_valid = 1; s.issue_waddr = 10; s.issue_lat = 5;
        apply_stimulus(s);
        s = idle(); apply_stimulus(s);
        s = idle(); s.flush = 1; s.issue_valid = 1; s.issue_waddr = 11; s.issue_lat = 3;
        apply_stimulus(s);
        s = idle(); s.rs_addr = 10; s.rs_use = 1; s.rt_addr = 11; s.rt_use = 1;
        apply_stimulus(s);

        // lat 4 without hold, reader stalls and is counted
        s = idle(); s.issue_valid = 1; s.issue_waddr = 3; s.issue_lat = 4;
        apply_stimulus(s);
        for (int k = 0; k < 6; k++) begin
            s = idle(); s.rt_addr = 3; s.rt_use = 1; s.rf2 = 32'h99;
            apply_stimulus(s);
        end

        // Asynchronous reset in the middle of a countdown
        s = idle(); s.issue_valid = 1; s.issue_waddr = 12; s.issue_lat = 6;
        apply_stimulus(s);
        s = idle(); s.rs_addr = 12; s.rs_use = 1;
        drive(s);
        #2 rst = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic over a small register window to provoke hazards
        for (int k = 0; k < 2000; k++) begin
            s = idle();
            s.issue_valid = ($urandom_range(0, 1) == 1);
            s.issue_waddr = AW'($urandom_range(0, 7));
            s.issue_lat   = LW'($urandom_range(0, 7));
            s.rs_addr     = AW'($urandom_range(0, 7));
            s.rt_addr     = AW'($urandom_range(0, 7));
            s.rs_use      = ($urandom_range(0, 9) < 7);
            s.rt_use      = ($urandom_range(0, 9) < 7);
            s.rf1         = $urandom;
            s.rf2         = $urandom;
            for (int i = 0; i < NFWD; i++) begin
                s.we[i] = ($urandom_range(0, 1) == 1);
                s.wa[i] = AW'($urandom_range(0, 7));
                s.wd[i] = $urandom;
            end
            s.hold  = ($urandom_range(0, 99) < 15);
            s.flush = ($urandom_range(0, 99) < 3);
            apply_stimulus(s);
        end

        @(negedge clk);
        #1;
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatch++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
